// File: rtl/game_round_ctrl.sv
// Round/level sequencer: turns win/lose pulses into timed result banners,
// tracks wins and lives, and advances levels or ends the game.
module game_round_ctrl #(
  parameter int unsigned WINS_PER_LEVEL = 5,
  parameter int unsigned MAX_LEVEL      = 9,
  parameter int unsigned LIVES_INIT     = 3,
  parameter int unsigned HOLD_CYCLES    = 50_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       win_pulse,
  input  logic       lose_pulse,
  output logic       round_active,
  output logic       show_win,
  output logic       show_lose,
  output logic       level_up,
  output logic       game_over,
  output logic       victory,
  output logic [3:0] level,
  output logic [3:0] level_wins,
  output logic [7:0] total_wins,
  output logic [2:0] lives,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    StIdle     = 3'd0,
    StPlay     = 3'd1,
    StWinHold  = 3'd2,
    StLoseHold = 3'd3,
    StLevelUp  = 3'd4,
    StGameOver = 3'd5,
    StVictory  = 3'd6
  } state_e;

  localparam int unsigned CntW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [CntW-1:0] HoldLast   = CntW'(HOLD_CYCLES - 1);
  localparam logic [3:0]      WinsTarget = 4'(WINS_PER_LEVEL);
  localparam logic [3:0]      LevelLast  = 4'(MAX_LEVEL);
  localparam logic [2:0]      LivesInit  = 3'(LIVES_INIT);

  state_e          state_q, state_d;
  logic [3:0]      level_q, level_d;
  logic [3:0]      level_wins_q, level_wins_d;
  logic [7:0]      total_wins_q, total_wins_d;
  logic [2:0]      lives_q, lives_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            hold_done;

  assign hold_done = (cnt_q == HoldLast);

  always_comb begin
    state_d      = state_q;
    level_d      = level_q;
    level_wins_d = level_wins_q;
    total_wins_d = total_wins_q;
    lives_d      = lives_q;
    cnt_d        = cnt_q;
    case (state_q)
      StIdle: begin
        if (start) state_d = StPlay;
      end
      StPlay: begin
        // Win has priority; a simultaneous lose pulse is dropped.
        if (win_pulse) begin
          state_d      = StWinHold;
          level_wins_d = level_wins_q + 4'd1;
          total_wins_d = (total_wins_q == 8'hFF) ? 8'hFF : total_wins_q + 8'd1;
          cnt_d        = '0;
        end else if (lose_pulse) begin
          state_d = StLoseHold;
          lives_d = lives_q - 3'd1;
          cnt_d   = '0;
        end
      end
      StWinHold: begin
        if (hold_done) begin
          cnt_d   = '0;
          state_d = (level_wins_q == WinsTarget) ? StLevelUp : StPlay;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StLoseHold: begin
        if (hold_done) begin
          cnt_d   = '0;
          state_d = (lives_q == 3'd0) ? StGameOver : StPlay;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StLevelUp: begin
        if (level_q < LevelLast) begin
          level_d      = level_q + 4'd1;
          level_wins_d = 4'd0;
          state_d      = StPlay;
        end else begin
          state_d = StVictory;
        end
      end
      StGameOver, StVictory: begin
        if (start) begin
          level_d      = 4'd1;
          level_wins_d = 4'd0;
          total_wins_d = 8'd0;
          lives_d      = LivesInit;
          state_d      = StPlay;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Flags are registered from the next state so they line up with state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      level_q      <= 4'd1;
      level_wins_q <= 4'd0;
      total_wins_q <= 8'd0;
      lives_q      <= LivesInit;
      cnt_q        <= '0;
      round_active <= 1'b0;
      show_win     <= 1'b0;
      show_lose    <= 1'b0;
      level_up     <= 1'b0;
      game_over    <= 1'b0;
      victory      <= 1'b0;
    end else begin
      state_q      <= state_d;
      level_q      <= level_d;
      level_wins_q <= level_wins_d;
      total_wins_q <= total_wins_d;
      lives_q      <= lives_d;
      cnt_q        <= cnt_d;
      round_active <= (state_d == StPlay);
      show_win     <= (state_d == StWinHold);
      show_lose    <= (state_d == StLoseHold);
      level_up     <= (state_d == StLevelUp);
      game_over    <= (state_d == StGameOver);
      victory      <= (state_d == StVictory);
    end
  end

  assign state      = state_q;
  assign level      = level_q;
  assign level_wins = level_wins_q;
  assign total_wins = total_wins_q;
  assign lives      = lives_q;

endmodule
